// File: rtl/log_arbiter.sv
// log_arbiter: shares one debug log sink between NUM_SOURCES requesters.
// A round-robin grant pushes at most one record per cycle into a
// first-word-fall-through FIFO that drives a valid/ready stream tagged with
// the source index. enable_i steps the collector through IDLE/RUN/DRAIN.
module log_arbiter #(
  parameter int NUM_SOURCES    = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int LOSSY          = 0,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              enable_i,
  input  logic [NUM_SOURCES-1:0]            src_valid_i,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data_i,
  output logic [NUM_SOURCES-1:0]            src_ready_o,
  output logic                              log_valid_o,
  output logic [DATA_WIDTH-1:0]             log_data_o,
  output logic [$clog2(NUM_SOURCES)-1:0]    log_src_o,
  input  logic                              log_ready_i,
  output logic [DROP_CNT_WIDTH-1:0]         drop_count_o,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o,
  output logic                              active_o
);

  localparam int SRC_W  = $clog2(NUM_SOURCES);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [SRC_W-1:0]      src;
    logic [DATA_WIDTH-1:0] data;
  } rec_t;

  state_t                    state, state_next;
  rec_t                      mem [FIFO_DEPTH];
  rec_t                      head_q;
  rec_t                      push_rec;
  logic [ADDR_W-1:0]         wr_ptr, rd_ptr, rd_ptr_next;
  logic [LVL_W-1:0]          level, level_next;
  logic [SRC_W-1:0]          rr_ptr;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  logic [NUM_SOURCES-1:0]    valid_rot;
  logic                      grant_valid;
  logic [SRC_W:0]            grant_off, grant_sum;
  logic [SRC_W-1:0]          grant_idx;
  logic                      full, push, pop, drop;

  assign full        = (level == LVL_W'(FIFO_DEPTH));
  assign pop         = (level != '0) && log_ready_i;
  assign rd_ptr_next = pop ? rd_ptr + ADDR_W'(1) : rd_ptr;

  // Rotate the requests so bit 0 is the source the pointer favours.
  assign valid_rot = NUM_SOURCES'({src_valid_i, src_valid_i} >> rr_ptr);

  // Cyclic priority search: lowest rotated offset wins, mapped back to an index.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_off   = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        grant_valid = 1'b1;
        grant_off   = (SRC_W+1)'(i);
      end
    end
    grant_sum = {1'b0, rr_ptr} + grant_off;
    if (grant_sum >= (SRC_W+1)'(NUM_SOURCES)) begin
      grant_sum = grant_sum - (SRC_W+1)'(NUM_SOURCES);
    end
    grant_idx = grant_sum[SRC_W-1:0];
  end

  // Select the granted source's record for the FIFO write port.
  always_comb begin
    push_rec     = '0;
    push_rec.src = grant_idx;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (SRC_W'(i) == grant_idx) begin
        push_rec.data = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state, source handshake and push/drop decisions.
  always_comb begin
    state_next  = state;
    src_ready_o = '0;
    push        = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE: begin
        src_ready_o = '1;
        if (enable_i) state_next = RUN;
      end
      RUN: begin
        if (!full) begin
          push = grant_valid;
          for (int i = 0; i < NUM_SOURCES; i++) begin
            src_ready_o[i] = grant_valid && (SRC_W'(i) == grant_idx);
          end
        end else if (LOSSY != 0) begin
          src_ready_o = '1;
          drop        = |src_valid_i;
        end
        if (!enable_i) state_next = DRAIN;
      end
      DRAIN: begin
        src_ready_o = '1;
        if (level == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LVL_W'(1);
      2'b01:   level_next = level - LVL_W'(1);
      default: level_next = level;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // FIFO storage.
  // NOTE: the array has no reset; level and pointers alone say which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  // FIFO pointers and level.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      rd_ptr <= rd_ptr_next;
      level  <= level_next;
    end
  end

  // Registered head: follows the new head entry, holds its value once empty.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q <= '0;
    end else if (level_next != '0) begin
      head_q <= (push && (rd_ptr_next == wr_ptr)) ? push_rec : mem[rd_ptr_next];
    end
  end

  // Round-robin pointer moves just past the source that was granted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant_idx == SRC_W'(NUM_SOURCES - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  // Saturating drop counter, cleared when a new logging session starts.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt <= '0;
    end else if (state == IDLE && enable_i) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

  assign log_valid_o  = (level != '0);
  assign log_data_o   = head_q.data;
  assign log_src_o    = head_q.src;
  assign drop_count_o = drop_cnt;
  assign fifo_level_o = level;
  assign active_o     = (state == RUN);

endmodule

// File: tb/tb_log_arbiter.sv
// tb_log_arbiter: drives a stalling (LOSSY=0) and a lossy (LOSSY=1, 4-bit drop
// counter) instance with the same stimulus. A queue-based model checks every
// output of both on each falling edge; directed steps add literal expectations.
module tb_log_arbiter;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } rec_t;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         enable;
  logic         log_ready;
  logic [3:0]   src_valid;
  logic [31:0]  sd [4];
  logic [127:0] src_data;

  logic [3:0]  rdy0, rdy1;
  logic        lv0, lv1;
  logic [31:0] ld0, ld1;
  logic [1:0]  ls0, ls1;
  logic [15:0] dc0;
  logic [3:0]  dc1;
  logic [3:0]  fl0, fl1;
  logic        act0, act1;

  int n_checks = 0;
  int n_pass   = 0;
  int acc;

  // Model state, one slot per instance.
  rec_t mq [2][$];
  int   mstate [2];
  int   mptr [2];
  int   mdrop [2];
  rec_t mlast [2];

  assign src_data = {sd[3], sd[2], sd[1], sd[0]};

  always #5 clk = ~clk;

  log_arbiter #(.NUM_SOURCES(4), .DATA_WIDTH(32), .FIFO_DEPTH(8), .LOSSY(0),
                .DROP_CNT_WIDTH(16)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable),
    .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(rdy0),
    .log_valid_o(lv0), .log_data_o(ld0), .log_src_o(ls0), .log_ready_i(log_ready),
    .drop_count_o(dc0), .fifo_level_o(fl0), .active_o(act0)
  );

  log_arbiter #(.NUM_SOURCES(4), .DATA_WIDTH(32), .FIFO_DEPTH(8), .LOSSY(1),
                .DROP_CNT_WIDTH(4)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable),
    .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(rdy1),
    .log_valid_o(lv1), .log_data_o(ld1), .log_src_o(ls1), .log_ready_i(log_ready),
    .drop_count_o(dc1), .fifo_level_o(fl1), .active_o(act1)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic int first_valid(input int from);
    logic [1:0] s;
    for (int k = 0; k < 4; k++) begin
      s = 2'(from + k);
      if (src_valid[s]) return int'(s);
    end
    return -1;
  endfunction

  // Compare instance i against the model, then advance the model over the next edge.
  task automatic model_cycle(input int i);
    int         g, sz, dmax;
    bit         full, lossy, do_push, do_pop;
    logic [3:0] exp_rdy, a_rdy, a_lvl;
    logic       a_valid, a_act;
    logic [31:0] a_data;
    logic [1:0] a_src;
    logic [15:0] a_drop;
    string      p;

    if (reset_i) begin
      mq[i].delete();
      mstate[i] = M_IDLE;
      mptr[i]   = 0;
      mdrop[i]  = 0;
      mlast[i]  = '0;
    end

    sz    = mq[i].size();
    full  = (sz == 8);
    lossy = (i == 1);
    dmax  = (i == 0) ? 65535 : 15;
    g     = first_valid(mptr[i]);

    if (mstate[i] != M_RUN) exp_rdy = 4'hF;
    else if (full)          exp_rdy = lossy ? 4'hF : 4'h0;
    else if (g >= 0)        exp_rdy = 4'b0001 << g;
    else                    exp_rdy = 4'h0;

    a_rdy   = (i == 0) ? rdy0 : rdy1;
    a_valid = (i == 0) ? lv0 : lv1;
    a_data  = (i == 0) ? ld0 : ld1;
    a_src   = (i == 0) ? ls0 : ls1;
    a_lvl   = (i == 0) ? fl0 : fl1;
    a_act   = (i == 0) ? act0 : act1;
    a_drop  = (i == 0) ? dc0 : {12'h000, dc1};

    p = $sformatf("d%0d", i);
    check({p, ".src_ready"}, a_rdy, exp_rdy);
    check({p, ".log_valid"}, a_valid, (sz != 0));
    check({p, ".log_data"}, a_data, mlast[i].data);
    check({p, ".log_src"}, a_src, mlast[i].src);
    check({p, ".fifo_level"}, a_lvl, sz);
    check({p, ".active"}, a_act, (mstate[i] == M_RUN));
    check({p, ".drop_count"}, a_drop, mdrop[i]);

    if (!reset_i) begin
      do_pop  = (sz != 0) && log_ready;
      do_push = (mstate[i] == M_RUN) && !full && (g >= 0);
      if (mstate[i] == M_RUN && full && lossy && src_valid != 4'h0)
        mdrop[i] = (mdrop[i] < dmax) ? mdrop[i] + 1 : dmax;
      if (do_pop) void'(mq[i].pop_front());
      if (do_push) begin
        mq[i].push_back({2'(g), sd[g]});
        mptr[i] = (g + 1) % 4;
      end
      case (mstate[i])
        M_IDLE:  if (enable) begin mstate[i] = M_RUN; mdrop[i] = 0; end
        M_RUN:   if (!enable) mstate[i] = M_DRAIN;
        default: if (sz == 0) mstate[i] = M_IDLE;
      endcase
      if (mq[i].size() != 0) mlast[i] = mq[i][0];
    end
  endtask

  // Per-cycle compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) model_cycle(i);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stream records from source s for ncyc cycles; data advances after each
  // acceptance by the stalling instance.
  task automatic run_src(input logic [1:0] s, input int ncyc, output int accepted);
    logic hit;
    accepted  = 0;
    src_valid = 4'b0001 << s;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      hit = rdy0[s];
      @(posedge clk);
      #1;
      if (hit) begin
        accepted++;
        sd[s] = sd[s] + 32'd1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i   = 1'b1;
    enable    = 1'b0;
    log_ready = 1'b0;
    src_valid = 4'h0;
    for (int k = 0; k < 4; k++) sd[k] = 32'h0;
    step(2);
    reset_i = 1'b0;
    check("reset.log_valid", lv0, 0);
    check("reset.fifo_level", fl0, 0);
    check("reset.active", act0, 0);
    check("reset.drop_count", dc0, 0);
    check("reset.log_data", ld0, 0);
    check("reset.src_ready_idle", rdy0, 4'hF);

    // Round-robin over four continuously valid sources.
    enable    = 1'b1;
    log_ready = 1'b1;
    src_valid = 4'hF;
    for (int k = 0; k < 4; k++) sd[k] = 32'hA0 + k;
    step(1);
    check("rr.run_entry_active", act0, 1);
    check("rr.no_valid_before_grant", lv0, 0);
    check("rr.first_grant_src0", rdy0, 4'b0001);
    step(1);
    check("rr.first_valid", lv0, 1);
    check("rr.data0", ld0, 32'hA0);
    check("rr.src0", ls0, 0);
    check("rr.next_grant_src1", rdy0, 4'b0010);
    for (int k = 1; k < 4; k++) begin
      step(1);
      check($sformatf("rr.data%0d", k), ld0, 32'hA0 + k);
      check($sformatf("rr.src%0d", k), ls0, k);
    end
    step(1);
    check("rr.wrap_data", ld0, 32'hA0);
    check("rr.wrap_src", ls0, 0);
    src_valid = 4'h0;
    enable    = 1'b0;
    step(4);
    check("rr.back_idle", act0, 0);
    check("rr.empty", fl0, 0);

    // Full FIFO: stalling vs lossy, drop counting and saturation.
    log_ready = 1'b0;
    enable    = 1'b1;
    step(1);
    sd[2] = 32'h200;
    run_src(2, 20, acc);
    check("full.accepted", acc, 8);
    check("full.level", fl0, 8);
    check("full.stalled_ready", rdy0, 4'h0);
    check("full.head_data", ld0, 32'h200);
    check("full.head_src", ls0, 2);
    check("lossy.level", fl1, 8);
    check("lossy.drops_12", dc1, 12);
    check("lossy.ready_all", rdy1, 4'hF);
    check("stall.no_drops", dc0, 0);
    run_src(2, 5, acc);
    check("full.still_stalled", acc, 0);
    check("lossy.saturated", dc1, 15);
    log_ready = 1'b1;
    #1;
    check("full.pop_does_not_unblock", rdy0, 4'h0);
    run_src(2, 1, acc);
    check("full.no_push_on_full_pop", acc, 0);
    check("full.level_after_pop", fl0, 7);
    check("full.next_head", ld0, 32'h201);
    check("full.resume_ready", rdy0, 4'b0100);
    run_src(2, 7, acc);
    check("full.steady_accepts", acc, 7);
    check("full.steady_level", fl0, 7);
    check("full.steady_head", ld0, 32'h208);
    src_valid = 4'h0;
    step(10);
    check("full.drained", fl0, 0);

    // Drain on disable with five records queued.
    log_ready = 1'b0;
    sd[0] = 32'h400;
    run_src(0, 5, acc);
    check("drain.queued", acc, 5);
    check("drain.level5", fl0, 5);
    enable    = 1'b0;
    src_valid = 4'h0;
    step(1);
    check("drain.inactive", act0, 0);
    check("drain.level_kept", fl0, 5);
    check("drain.ready_all", rdy0, 4'hF);
    log_ready = 1'b1;
    src_valid = 4'b0010;
    sd[1]     = 32'h555;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check($sformatf("drain.level%0d", 5 - k), fl0, 5 - k);
      check($sformatf("drain.data%0d", k), ld0, 32'h400 + ((k < 4) ? k : 4));
    end
    enable    = 1'b1;
    src_valid = 4'h0;
    step(1);
    check("drain.idle_ignores_enable", act0, 0);
    check("drain.drops_kept", dc1, 15);
    step(1);
    check("rerun.active", act0, 1);
    check("rerun.drop_cleared", dc1, 0);

    // Asynchronous reset with three records queued.
    log_ready = 1'b0;
    sd[3] = 32'h300;
    run_src(3, 3, acc);
    check("areset.queued", acc, 3);
    check("areset.level3", fl0, 3);
    src_valid = 4'h0;
    #2;
    reset_i = 1'b1;
    #1;
    check("areset.log_valid", lv0, 0);
    check("areset.level", fl0, 0);
    check("areset.active", act0, 0);
    check("areset.log_data", ld0, 0);
    check("areset.lossy_valid", lv1, 0);
    check("areset.lossy_level", fl1, 0);
    @(posedge clk);
    #1;
    reset_i   = 1'b0;
    enable    = 1'b1;
    log_ready = 1'b1;
    src_valid = 4'hF;
    for (int k = 0; k < 4; k++) sd[k] = 32'hA0 + k;
    step(1);
    check("areset.grant_src0_first", rdy0, 4'b0001);
    check("areset.run", act0, 1);
    step(1);
    check("areset.first_data", ld0, 32'hA0);
    check("areset.first_src", ls0, 0);
    src_valid = 4'h0;
    enable    = 1'b0;
    step(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/log_arbiter.md
Name: log_arbiter

Overview:
- Synthesizable collector that shares one debug log/trace sink between NUM_SOURCES pipeline-stage requesters.
- Each cycle it round-robin-grants at most one source record into a FIFO and presents records on a single valid/ready stream, tagged with the source index.
- The stream feeds the trace UART or trace RAM.
- Start/stop is controlled by enable_i, the hardware counterpart of the simulation start/stop logging hooks.

Parameters:
- NUM_SOURCES, 4, number of requesters (2..8).
- DATA_WIDTH, 32, bits per log record.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, >=2.
- LOSSY, 0. 1 = discard and count records when the FIFO is full; 0 = stall the sources.
- DROP_CNT_WIDTH, 16, drop counter width.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  logging enable (level).
- src_valid_i  in  NUM_SOURCES  per-source record valid.
- src_data_i  in  NUM_SOURCES*DATA_WIDTH  packed records; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- src_ready_o  out  NUM_SOURCES  per-source accept, combinational.
- log_valid_o  out  1  output record valid.
- log_data_o  out  DATA_WIDTH  output record.
- log_src_o  out  $clog2(NUM_SOURCES)  index of the source that produced the output record.
- log_ready_i  in  1  sink accept.
- drop_count_o  out  DROP_CNT_WIDTH  saturating count of drop cycles.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- active_o  out  1  high while state is RUN.

Behaviour:
- Reset values (async): state IDLE, FIFO empty, round-robin pointer 0 (source 0 has highest priority), drop_count_o 0, log_valid_o 0, log_data_o 0, log_src_o 0, fifo_level_o 0, active_o 0.
- Handshakes: a transfer occurs when valid and ready are both high on a rising clk_i edge. Sources must hold data stable while valid && !ready.

State machine (IDLE, RUN, DRAIN):
- IDLE:
  - src_ready_o = all ones; records are sunk and discarded, not counted.
  - enable_i=1 moves to RUN next cycle and clears drop_count_o on that edge.
- RUN:
  - Grant = first valid source at or after the pointer, searching cyclically.
  - Push occurs only if the FIFO is not full at the start of the cycle. Full blocks the push even if a pop happens in the same cycle.
  - src_ready_o is one-hot on the grant. After a grant, the pointer moves to grant+1 mod NUM_SOURCES; with no grant, the pointer is unchanged.
  - FIFO full with LOSSY=0: src_ready_o = 0.
  - FIFO full with LOSSY=1: src_ready_o = all ones, records are discarded, and drop_count_o increments by 1 in any cycle with >=1 valid source. The counter saturates at all ones. The pointer is unchanged.
  - enable_i=0 moves to DRAIN next cycle.
- DRAIN:
  - src_ready_o = all ones; records are discarded, not counted.
  - The FIFO keeps emptying.
  - When the FIFO is empty, move to IDLE. enable_i is ignored until IDLE is reached.

FIFO and output:
- First-word-fall-through.
- log_valid_o = level != 0; log_data_o and log_src_o come from the head entry.
- A record accepted on edge N is visible on log_valid_o after edge N (latency 1 cycle).
- Simultaneous push and pop leaves the level unchanged.
- Pointers wrap modulo FIFO_DEPTH; the level is tracked separately so full and empty are unambiguous.
- When empty, log_data_o and log_src_o hold their last values.

Reset mid-operation:
- FIFO contents are lost, state goes to IDLE, outputs take their reset values immediately.

Test Plan:
1. Reset, enable_i=1, FIFO_DEPTH=8, log_ready_i=1, all 4 sources valid continuously with data = 0xA0+k → grants 0,1,2,3,0,…; output sequence 0xA0,0xA1,0xA2,0xA3 with log_src_o 0..3; first log_valid_o one cycle after the first grant.
2. LOSSY=0, log_ready_i=0, source 2 streaming → 8 records accepted, fifo_level_o=8, src_ready_o=0 thereafter. Raising log_ready_i pops 8 records in order, and acceptance resumes only once the level drops below 8.
3. LOSSY=1, log_ready_i=0, source 1 valid for 20 cycles after RUN entry → 8 accepted, drop_count_o=12. Re-entering RUN clears drop_count_o to 0.
4. With 5 records queued, drop enable_i → active_o=0 next cycle; all 5 records are still emitted; src_ready_o=all ones in DRAIN; IDLE is reached the cycle after empty; no new pushes.
5. Assert reset_i asynchronously mid-burst with 3 records queued → log_valid_o=0 and fifo_level_o=0 immediately. After release with enable_i=1, source 0 is granted first.
6. DROP_CNT_WIDTH=4, LOSSY=1, FIFO held full with sources valid for 20 cycles → drop_count_o saturates at 15.
